// File: rtl/store_merge_unit_if.sv
// Store request bus from the MEM stage plus the word-only cache port.
// The slave modport is the merge unit's side; master is the CPU/memory side.
interface store_merge_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [1:0]        req_size;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_req;
  logic              mem_wr_req;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  req_valid, req_addr, req_data, req_size, mem_rdata, mem_ack,
    output req_ready, done, err, mem_addr, mem_rd_req, mem_wr_req, mem_wdata
  );

  modport master (
    output req_valid, req_addr, req_data, req_size, mem_rdata, mem_ack,
    input  req_ready, done, err, mem_addr, mem_rd_req, mem_wr_req, mem_wdata
  );
endinterface

// File: rtl/store_merge_unit.sv
// Narrows sb/sh/sw stores onto a word-only memory port; sub-word stores
// do read-modify-write of the aligned word.
module store_merge_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  store_merge_unit_if.slave    bus
);
  localparam int NUM_LANES = DATA_W / 8;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_ERR} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic                            accept, bad;
  logic [NUM_LANES-1:0]            lane_en;
  logic [NUM_LANES-1:0][7:0]       lane_src;
  logic [NUM_LANES-1:0][7:0]       merged;

  assign accept = bus.req_valid && (state_q == S_IDLE);
  assign bad    = (bus.req_size == 2'b11) ||
                  (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                  (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);

  // Byte/half enables from the latched request; source replicated per lane.
  always_comb begin
    lane_en = '0;
    case (size_q)
      2'b00:   lane_en[addr_q[1:0]] = 1'b1;
      2'b01:   lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = '0;
    endcase
  end

  assign lane_src = (size_q == 2'b01) ? {2{data_q[15:0]}} : {4{data_q[7:0]}};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign merged[g] = lane_en[g] ? lane_src[g] : bus.mem_rdata[8*g +: 8];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: if (accept) begin
        addr_d = bus.req_addr;
        data_d = bus.req_data[15:0];
        size_d = bus.req_size;
        if (bad) begin
          state_d = S_ERR;
        end else if (bus.req_size == 2'b10) begin
          state_d = S_WRITE;
          wdata_d = bus.req_data;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: if (bus.mem_ack) begin
        wdata_d = merged;
        state_d = S_WRITE;
      end
      S_WRITE: if (bus.mem_ack) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
    end
  end

  // Handshakes decode from state only; no input-to-output combinational path.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.mem_rd_req = (state_q == S_READ);
  assign bus.mem_wr_req = (state_q == S_WRITE);
  assign bus.done       = (state_q == S_DONE) || (state_q == S_ERR);
  assign bus.err        = (state_q == S_ERR);
  assign bus.mem_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_wdata  = wdata_q;
endmodule

// File: tb/tb_store_merge_unit.sv
// Bench for store_merge_unit: memory responder with programmable wait states,
// expected writes queued at issue and matched against observed writes.
module tb_store_merge_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_merge_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  store_merge_unit #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         obs_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int          checks = 0;
  int          failures = 0;
  int          rd_delay = 0, wr_delay = 0;
  int          rd_cycles = 0, wr_cycles = 0, stab_err = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] d,
                                            input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] w;
    w = old;
    case (sz)
      2'b00: case (off)
        2'd0: w[7:0]   = d[7:0];
        2'd1: w[15:8]  = d[7:0];
        2'd2: w[23:16] = d[7:0];
        2'd3: w[31:24] = d[7:0];
      endcase
      2'b01: if (off[1]) w[31:16] = d[15:0]; else w[15:0] = d[15:0];
      default: w = d;
    endcase
    return w;
  endfunction

  // Memory responder: acks after *_delay wait cycles, tracks request stability.
  initial begin
    int          wait_cnt;
    bit          active;
    logic [31:0] hold_addr, hold_wdata;
    wait_cnt = 0; active = 0; hold_addr = '0; hold_wdata = '0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = 32'h0BAD_F00D;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      bus.mem_rdata = 32'h0BAD_F00D;
      if (bus.mem_rd_req || bus.mem_wr_req) begin
        if (bus.mem_rd_req) rd_cycles++;
        if (bus.mem_wr_req) wr_cycles++;
        if (active && bus.mem_addr !== hold_addr) stab_err++;
        if (active && bus.mem_wr_req && bus.mem_wdata !== hold_wdata) stab_err++;
        hold_addr = bus.mem_addr;
        hold_wdata = bus.mem_wdata;
        if (wait_cnt == (bus.mem_rd_req ? rd_delay : wr_delay)) begin
          bus.mem_ack = 1'b1;
          wait_cnt = 0;
          active = 0;
          if (bus.mem_rd_req) bus.mem_rdata = mem_rd(bus.mem_addr);
          else begin
            obs_q.push_back('{addr: bus.mem_addr, data: bus.mem_wdata});
            mem_model[bus.mem_addr] = bus.mem_wdata;
          end
        end else begin
          wait_cnt++;
          active = 1;
        end
      end else begin
        wait_cnt = 0;
        active = 0;
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input int exp_lat, input int exp_rd, input int exp_wr,
                          input bit exp_err, input bit noise, input string nm);
    int  lat;
    wr_t e, o;
    @(posedge clk); #2;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL %s ready_before got=%b want=1", nm, bus.req_ready);
    end
    rd_cycles = 0; wr_cycles = 0; stab_err = 0;
    if (!exp_err) begin
      e.addr = {a[31:2], 2'b00};
      e.data = ref_merge(mem_rd(e.addr), d, sz, a[1:0]);
      exp_q.push_back(e);
    end
    bus.req_valid = 1'b1; bus.req_addr = a; bus.req_data = d; bus.req_size = sz;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    lat = 0;
    while (1) begin
      lat++;
      if (bus.done === 1'b1 || lat >= 40) break;
      if (noise) begin
        bus.req_valid = lat[0]; bus.req_addr = 32'h0000_0ABC; bus.req_size = 2'b10;
      end
      @(posedge clk); #2;
    end
    bus.req_valid = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || lat != exp_lat) begin
      failures++; $display("FAIL %s latency got=%0d done=%b want=%0d", nm, lat, bus.done, exp_lat);
    end
    checks++;
    if (bus.err !== exp_err) begin
      failures++; $display("FAIL %s err got=%b want=%b", nm, bus.err, exp_err);
    end
    checks++;
    if (rd_cycles != exp_rd || wr_cycles != exp_wr) begin
      failures++; $display("FAIL %s req_cycles got rd=%0d wr=%0d want rd=%0d wr=%0d",
                           nm, rd_cycles, wr_cycles, exp_rd, exp_wr);
    end
    checks++;
    if (stab_err != 0) begin
      failures++; $display("FAIL %s stability got=%0d want=0", nm, stab_err);
    end
    checks++;
    if (!exp_err) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        failures++; $display("FAIL %s write missing want addr=%h data=%h", nm, e.addr, e.data);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          failures++; $display("FAIL %s write got addr=%h data=%h want addr=%h data=%h",
                               nm, o.addr, o.data, e.addr, e.data);
        end
      end
    end else if (obs_q.size() != 0) begin
      failures++; $display("FAIL %s err_write got=%0d writes want=0", nm, obs_q.size());
      obs_q.delete();
    end
    @(posedge clk); #2;
    checks++;
    if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL %s after_done got done=%b ready=%b want 0/1", nm, bus.done, bus.req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if ({bus.req_ready, bus.mem_rd_req, bus.mem_wr_req, bus.done, bus.err} !== 5'b10000 ||
        bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      failures++; $display("FAIL reset got ready=%b rd=%b wr=%b done=%b err=%b addr=%h wdata=%h want 1/0/0/0/0/0/0",
                           bus.req_ready, bus.mem_rd_req, bus.mem_wr_req, bus.done, bus.err,
                           bus.mem_addr, bus.mem_wdata);
    end
    rst = 1'b0;
    @(posedge clk); #2;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_release got ready=%b done=%b want 1/0", bus.req_ready, bus.done);
    end
  endtask

  task automatic test_sw();
    do_store(32'h100, 32'hDEAD_BEEF, 2'b10, 2, 0, 1, 1'b0, 1'b0, "sw");
    checks++;
    if (mem_rd(32'h100) !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL sw_word got=%h want=deadbeef", mem_rd(32'h100));
    end
  endtask

  task automatic test_sb();
    mem_model[32'h200] = 32'h1122_3344;
    do_store(32'h203, 32'h0000_00A5, 2'b00, 3, 1, 1, 1'b0, 1'b0, "sb");
    checks++;
    if (mem_rd(32'h200) !== 32'hA522_3344) begin
      failures++; $display("FAIL sb_word got=%h want=a5223344", mem_rd(32'h200));
    end
    mem_model[32'h204] = 32'hFFFF_FFFF;
    do_store(32'h205, 32'h1234_5600, 2'b00, 3, 1, 1, 1'b0, 1'b0, "sb_lane1");
  endtask

  task automatic test_sh();
    mem_model[32'h300] = 32'hAABB_CCDD;
    do_store(32'h302, 32'hFFFF_1234, 2'b01, 3, 1, 1, 1'b0, 1'b0, "sh_hi");
    checks++;
    if (mem_rd(32'h300) !== 32'h1234_CCDD) begin
      failures++; $display("FAIL sh_hi_word got=%h want=1234ccdd", mem_rd(32'h300));
    end
    mem_model[32'h300] = 32'hAABB_CCDD;
    do_store(32'h300, 32'hFFFF_1234, 2'b01, 3, 1, 1, 1'b0, 1'b0, "sh_lo");
    checks++;
    if (mem_rd(32'h300) !== 32'hAABB_1234) begin
      failures++; $display("FAIL sh_lo_word got=%h want=aabb1234", mem_rd(32'h300));
    end
  endtask

  task automatic test_misaligned();
    do_store(32'h401, 32'h1111_2222, 2'b01, 1, 0, 0, 1'b1, 1'b0, "sh_mis");
    do_store(32'h402, 32'h3333_4444, 2'b10, 1, 0, 0, 1'b1, 1'b0, "sw_mis");
    do_store(32'h600, 32'h5555_6666, 2'b11, 1, 0, 0, 1'b1, 1'b0, "size11");
  endtask

  task automatic test_wait_states();
    mem_model[32'h500] = 32'h5566_7788;
    rd_delay = 3; wr_delay = 2;
    do_store(32'h500, 32'hCAFE_0099, 2'b00, 8, 4, 3, 1'b0, 1'b1, "wait");
    rd_delay = 0; wr_delay = 0;
    checks++;
    if (mem_rd(32'h500) !== 32'h5566_7799) begin
      failures++; $display("FAIL wait_word got=%h want=55667799", mem_rd(32'h500));
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    mem_model[32'h700] = 32'h0102_0304;
    wr_delay = 10;
    @(posedge clk); #2;
    wr_cycles = 0;
    bus.req_valid = 1'b1; bus.req_addr = 32'h701; bus.req_data = 32'hEE; bus.req_size = 2'b00;
    @(posedge clk); #2;
    bus.req_valid = 1'b0;
    guard = 0;
    while (wr_cycles == 0 && guard < 20) begin
      @(posedge clk); #2;
      guard++;
    end
    checks++;
    if (bus.mem_wr_req !== 1'b1) begin
      failures++; $display("FAIL rst_mid_in_write got wr=%b want=1", bus.mem_wr_req);
    end
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1 || bus.mem_wr_req !== 1'b0 || bus.done !== 1'b0 ||
        bus.mem_wdata !== 32'h0) begin
      failures++; $display("FAIL rst_mid got ready=%b wr=%b done=%b wdata=%h want 1/0/0/0",
                           bus.req_ready, bus.mem_wr_req, bus.done, bus.mem_wdata);
    end
    checks++;
    if (obs_q.size() != 0 || mem_rd(32'h700) !== 32'h0102_0304) begin
      failures++; $display("FAIL rst_mid_dropped got writes=%0d word=%h want 0/01020304",
                           obs_q.size(), mem_rd(32'h700));
    end
    wr_delay = 0;
    do_store(32'h704, 32'h0BAD_CAFE, 2'b10, 2, 0, 1, 1'b0, 1'b0, "sw_after_rst");
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_data = '0; bus.req_size = '0;
    rst = 1'b1;
    test_reset();
    test_sw();
    test_sb();
    test_sh();
    test_misaligned();
    test_wait_states();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule
